// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, functs, ALU controls and FSM states.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2a;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == OpRtype) return fn inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt, FnJr};
    return op inside {OpJ, OpJal, OpBeq, OpBne, OpAddi, OpLw, OpSw};
  endfunction

  function automatic logic [3:0] alu_ctrl(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] ctrl;
    ctrl = AluAdd;
    if (op == OpBeq || op == OpBne) begin
      ctrl = AluSub;
    end else if (op == OpRtype) begin
      case (fn)
        FnSub:   ctrl = AluSub;
        FnAnd:   ctrl = AluAnd;
        FnOr:    ctrl = AluOr;
        FnSlt:   ctrl = AluSlt;
        default: ctrl = AluAdd;
      endcase
    end
    return ctrl;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous reads, one synchronous write, $0 hardwired to zero.
module mips_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != 5'd0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS core with request/ready instruction and data memory ports.
// Halts on illegal instructions or misaligned data accesses until reset.
module multicycle_mips
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DMEM_AW  = 7
) (
  input  logic               CLK,
  input  logic               RST,
  output logic [31:0]        IR_addr,
  output logic               I_req,
  input  logic               I_ready,
  input  logic [31:0]        IR,
  output logic               D_req,
  output logic               D_we,
  output logic [DMEM_AW-1:0] A,
  output logic [31:0]        D_wdata,
  input  logic [31:0]        D_rdata,
  input  logic               D_ready,
  output logic [31:0]        RF_writedata,
  output logic               RF_we,
  output logic               retire,
  output logic               trap
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, a_q, b_q, imm_q, alu_q, mdr_q;
  logic [31:0] rs_data, rt_data, alu_b, alu_res, pc_plus4, br_target, j_target, rf_wdata;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, rf_waddr;
  logic [3:0]  alu_op;
  logic        rf_wreq, is_mem, is_ctrl, br_taken, misaligned;

  assign op = ir_q[31:26];
  assign rs = ir_q[25:21];
  assign rt = ir_q[20:16];
  assign rd = ir_q[15:11];
  assign fn = ir_q[5:0];

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {imm_q[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};
  assign is_mem    = (op == OpLw) || (op == OpSw);
  assign is_ctrl   = (op == OpBeq) || (op == OpBne) || (op == OpJ) || (op == OpJal) ||
                     (op == OpRtype && fn == FnJr);

  assign alu_op = alu_ctrl(op, fn);
  assign alu_b  = (op == OpRtype || op == OpBeq || op == OpBne) ? b_q : imm_q;

  always_comb begin
    case (alu_op)
      AluSub:  alu_res = a_q - alu_b;
      AluAnd:  alu_res = a_q & alu_b;
      AluOr:   alu_res = a_q | alu_b;
      AluSlt:  alu_res = {31'd0, $signed(a_q) < $signed(alu_b)};
      default: alu_res = a_q + alu_b;
    endcase
  end

  // Branch compare reuses the ALU subtract: zero result means equal operands.
  assign br_taken   = (op == OpBeq) ? (alu_res == 32'd0) : (alu_res != 32'd0);
  assign misaligned = alu_res[1:0] != 2'b00;

  mips_regfile u_regfile (
    .clk_i    (CLK),
    .rst_i    (RST),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rs_data),
    .rdata2_o (rt_data),
    .we_i     (RF_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= StFetch;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (I_ready) state_d = StDecode;
      StDecode: state_d = is_legal(op, fn) ? StExec : StHalt;
      StExec: begin
        if (is_ctrl)     state_d = StFetch;
        else if (is_mem) state_d = misaligned ? StHalt : StMem;
        else             state_d = StWb;
      end
      StMem:    if (D_ready) state_d = (op == OpSw) ? StFetch : StWb;
      StWb:     state_d = StFetch;
      default:  state_d = StHalt;
    endcase
  end

  always_comb begin
    I_req    = 1'b0;
    D_req    = 1'b0;
    D_we     = 1'b0;
    rf_wreq  = 1'b0;
    rf_waddr = rt;
    rf_wdata = 32'd0;
    retire   = 1'b0;
    trap     = 1'b0;
    pc_d     = pc_q;
    case (state_q)
      StFetch: I_req = 1'b1;
      StExec: begin
        if (is_ctrl) begin
          retire = 1'b1;
          if (op == OpBeq || op == OpBne) pc_d = br_taken ? br_target : pc_plus4;
          else if (op == OpRtype)         pc_d = a_q;
          else                            pc_d = j_target;
          if (op == OpJal) begin
            rf_wreq  = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc_plus4;
          end
        end
      end
      StMem: begin
        D_req = 1'b1;
        D_we  = (op == OpSw);
        if (D_ready && op == OpSw) begin
          retire = 1'b1;
          pc_d   = pc_plus4;
        end
      end
      StWb: begin
        rf_wreq  = 1'b1;
        rf_waddr = (op == OpRtype) ? rd : rt;
        rf_wdata = (op == OpLw) ? mdr_q : alu_q;
        retire   = 1'b1;
        pc_d     = pc_plus4;
      end
      StHalt:  trap = 1'b1;
      default: ;
    endcase
    if (RST) begin
      I_req    = 1'b0;
      D_req    = 1'b0;
      D_we     = 1'b0;
      rf_wreq  = 1'b0;
      rf_wdata = 32'd0;
      retire   = 1'b0;
      trap     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (state_q == StFetch && I_ready) ir_q <= IR;
      if (state_q == StDecode) begin
        a_q   <= rs_data;
        b_q   <= rt_data;
        imm_q <= {{16{ir_q[15]}}, ir_q[15:0]};
      end
      if (state_q == StExec) alu_q <= alu_res;
      if (state_q == StMem && D_ready && op == OpLw) mdr_q <= D_rdata;
    end
  end

  assign RF_we        = rf_wreq && (rf_waddr != 5'd0);
  assign RF_writedata = rf_wdata;
  assign IR_addr      = RST ? RESET_PC : pc_q;
  // Upper address bits are dropped so data accesses wrap within the memory.
  assign A            = alu_q[DMEM_AW+1:2];
  assign D_wdata      = b_q;

endmodule

// File: tb/tb_multicycle_mips.sv
// Directed bench for multicycle_mips: table of ALU ops plus hand-written memory,
// branch, halt and reset sequences against a stallable instruction/data memory model.
module tb_multicycle_mips;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] IR_addr, IR = 32'd0, D_wdata, D_rdata = 32'd0, RF_writedata;
  logic        I_req, I_ready = 1'b0, D_req, D_we, D_ready = 1'b0, RF_we, retire, trap;
  logic [6:0]  A;

  always #5 clk = ~clk;

  multicycle_mips dut (
    .CLK          (clk),
    .RST          (rst),
    .IR_addr      (IR_addr),
    .I_req        (I_req),
    .I_ready      (I_ready),
    .IR           (IR),
    .D_req        (D_req),
    .D_we         (D_we),
    .A            (A),
    .D_wdata      (D_wdata),
    .D_rdata      (D_rdata),
    .D_ready      (D_ready),
    .RF_writedata (RF_writedata),
    .RF_we        (RF_we),
    .retire       (retire),
    .trap         (trap)
  );

  logic [31:0] imem [256];
  logic [31:0] dmem [128];
  int          i_stall = 0, d_stall = 0, i_cnt = 0, d_cnt = 0;
  int          checks = 0, failures = 0;
  logic [6:0]  a_prev = 7'd0, acc_a = 7'd0;
  logic [31:0] wd_prev = 32'd0, acc_wd = 32'd0;
  logic        dreq_prev = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  // Memory model: decides ready 2 time units after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (I_req === 1'b1) begin
      if (i_cnt >= i_stall) begin
        I_ready = 1'b1;
        IR      = imem[IR_addr[9:2]];
        i_cnt   = 0;
      end else begin
        I_ready = 1'b0;
        i_cnt++;
      end
    end else begin
      I_ready = 1'b0;
      i_cnt   = 0;
    end
    if (D_req === 1'b1) begin
      if (dreq_prev) begin
        check32("dmem_addr_stable", {25'd0, A}, {25'd0, a_prev});
        check32("dmem_wdata_stable", D_wdata, wd_prev);
      end
      a_prev  = A;
      wd_prev = D_wdata;
      if (d_cnt >= d_stall) begin
        D_ready = 1'b1;
        D_rdata = dmem[A];
        acc_a   = A;
        acc_wd  = D_wdata;
        if (D_we) dmem[A] = D_wdata;
        d_cnt   = 0;
      end else begin
        D_ready = 1'b0;
        d_cnt++;
      end
    end else begin
      D_ready = 1'b0;
      d_cnt   = 0;
    end
    dreq_prev = (D_req === 1'b1);
  end

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #3;
    check32("rst_i_req", {31'd0, I_req}, 32'd0);
    check32("rst_d_req", {31'd0, D_req}, 32'd0);
    check32("rst_d_we", {31'd0, D_we}, 32'd0);
    check32("rst_rf_we", {31'd0, RF_we}, 32'd0);
    check32("rst_retire", {31'd0, retire}, 32'd0);
    check32("rst_trap", {31'd0, trap}, 32'd0);
    check32("rst_ir_addr", IR_addr, 32'd0);
    check32("rst_rf_wdata", RF_writedata, 32'd0);
    rst = 1'b0;
  endtask

  // Runs one instruction from its first FETCH cycle to its retire cycle.
  task automatic step(output logic [31:0] pc0, output int cyc, output int we_cnt,
                      output logic [31:0] wd);
    cyc = 0;
    we_cnt = 0;
    wd = 32'd0;
    pc0 = 32'hFFFF_FFFF;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #3;
      cyc++;
      if (cyc == 1) pc0 = IR_addr;
      if (RF_we === 1'b1) begin
        we_cnt++;
        wd = RF_writedata;
      end
      if (retire === 1'b1) break;
    end
  endtask

  task automatic step_check(input string name, input logic [31:0] e_pc, input int e_cyc,
                            input int e_we, input logic [31:0] e_wd);
    logic [31:0] pc0, wd;
    int          cyc, we_cnt;
    step(pc0, cyc, we_cnt, wd);
    check32({name, "_pc"}, pc0, e_pc);
    check32({name, "_cycles"}, 32'(cyc), 32'(e_cyc));
    check32({name, "_rf_we"}, 32'(we_cnt), 32'(e_we));
    check32({name, "_rf_wdata"}, wd, e_wd);
  endtask

  task automatic run_to_trap(input string name, input int e_cyc);
    int   cyc;
    logic saw_dreq;
    cyc = 0;
    saw_dreq = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #3;
      cyc++;
      if (D_req !== 1'b0) saw_dreq = 1'b1;
      if (trap === 1'b1) break;
    end
    check32({name, "_trap_cycle"}, 32'(cyc), 32'(e_cyc));
    check32({name, "_no_dreq"}, {31'd0, saw_dreq}, 32'd0);
    repeat (3) @(posedge clk);
    #3;
    check32({name, "_trap_held"}, {31'd0, trap}, 32'd1);
    check32({name, "_halt_no_ireq"}, {31'd0, I_req}, 32'd0);
    check32({name, "_halt_no_retire"}, {31'd0, retire}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] instr;
    int          cyc;
    int          we;
    logic [31:0] wd;
  } vec_t;

  vec_t tv [13];

  initial begin
    for (int k = 0; k < 256; k++) imem[k] = 32'd0;
    for (int k = 0; k < 128; k++) dmem[k] = 32'd0;

    tv[0]  = '{enc_i(OpAddi, 5'd0, 5'd1, 16'd5),   4, 1, 32'd5};
    tv[1]  = '{enc_i(OpAddi, 5'd0, 5'd2, 16'd7),   4, 1, 32'd7};
    tv[2]  = '{enc_r(FnAdd, 5'd1, 5'd2, 5'd3),     4, 1, 32'd12};
    tv[3]  = '{enc_r(FnSub, 5'd1, 5'd2, 5'd4),     4, 1, 32'hFFFF_FFFE};
    tv[4]  = '{enc_r(FnAnd, 5'd1, 5'd2, 5'd5),     4, 1, 32'd5};
    tv[5]  = '{enc_r(FnOr, 5'd1, 5'd2, 5'd6),      4, 1, 32'd7};
    tv[6]  = '{enc_r(FnSlt, 5'd4, 5'd1, 5'd7),     4, 1, 32'd1};
    tv[7]  = '{enc_r(FnSlt, 5'd1, 5'd4, 5'd8),     4, 1, 32'd0};
    tv[8]  = '{enc_i(OpAddi, 5'd0, 5'd0, 16'd5),   4, 0, 32'd0};
    tv[9]  = '{enc_r(FnAdd, 5'd0, 5'd0, 5'd5),     4, 1, 32'd0};
    tv[10] = '{enc_i(OpAddi, 5'd1, 5'd10, 16'hFFF8), 4, 1, 32'hFFFF_FFFD};
    tv[11] = '{enc_r(FnAdd, 5'd4, 5'd2, 5'd11),    4, 1, 32'd5};
    tv[12] = '{enc_r(FnOr, 5'd5, 5'd6, 5'd12),     4, 1, 32'd7};

    // ALU table, zero-wait memory
    for (int k = 0; k < 13; k++) imem[k] = tv[k].instr;
    do_reset();
    for (int k = 0; k < 13; k++)
      step_check($sformatf("tv%0d", k), 32'(4 * k), tv[k].cyc, tv[k].we, tv[k].wd);

    // Loads and stores with stalls, plus address wrap
    dmem[5] = 32'hDEAD_BEEF;
    imem[0] = enc_i(OpLw, 5'd0, 5'd2, 16'd20);
    imem[1] = enc_i(OpSw, 5'd0, 5'd2, 16'd8);
    imem[2] = enc_i(OpLw, 5'd0, 5'd4, 16'd8);
    imem[3] = enc_i(OpLw, 5'd0, 5'd12, 16'h0208);
    do_reset();
    step_check("lw_seed", 32'h0, 5, 1, 32'hDEAD_BEEF);
    i_stall = 3;
    d_stall = 3;
    step_check("sw_stall", 32'h4, 10, 0, 32'd0);
    check32("sw_addr", {25'd0, acc_a}, 32'd2);
    check32("sw_wdata", acc_wd, 32'hDEAD_BEEF);
    check32("sw_dmem", dmem[2], 32'hDEAD_BEEF);
    step_check("lw_stall", 32'h8, 11, 1, 32'hDEAD_BEEF);
    i_stall = 0;
    d_stall = 0;
    step_check("lw_wrap", 32'hC, 5, 1, 32'hDEAD_BEEF);
    check32("lw_wrap_addr", {25'd0, acc_a}, 32'd2);

    // Branches and jumps
    for (int k = 0; k < 256; k++) imem[k] = 32'd0;
    imem[0]  = enc_i(OpAddi, 5'd0, 5'd1, 16'd3);
    imem[1]  = enc_j(OpJ, 26'h4);
    imem[4]  = enc_i(OpBeq, 5'd1, 5'd1, 16'hFFFF);
    imem[5]  = enc_i(OpBne, 5'd1, 5'd1, 16'd4);
    imem[6]  = enc_j(OpJal, 26'h40);
    imem[7]  = enc_r(FnAdd, 5'd31, 5'd0, 5'd14);
    imem[64] = enc_i(OpBne, 5'd1, 5'd0, 16'd2);
    imem[67] = enc_r(FnJr, 5'd31, 5'd0, 5'd0);
    do_reset();
    step_check("br_addi", 32'h0, 4, 1, 32'd3);
    step_check("j", 32'h4, 3, 0, 32'd0);
    step_check("beq_taken", 32'h10, 3, 0, 32'd0);
    imem[4] = enc_r(FnAdd, 5'd1, 5'd1, 5'd9);
    step_check("after_beq", 32'h10, 4, 1, 32'd6);
    step_check("bne_not_taken", 32'h14, 3, 0, 32'd0);
    step_check("jal", 32'h18, 3, 1, 32'h1C);
    step_check("bne_taken", 32'h100, 3, 0, 32'd0);
    step_check("jr", 32'h10C, 3, 0, 32'd0);
    step_check("read_r31", 32'h1C, 4, 1, 32'h1C);

    // Halts: misaligned lw, illegal opcode, illegal funct; reset recovers
    for (int k = 0; k < 256; k++) imem[k] = 32'd0;
    imem[0] = enc_i(OpAddi, 5'd0, 5'd1, 16'd6);
    imem[1] = enc_i(OpLw, 5'd1, 5'd2, 16'd0);
    do_reset();
    step_check("halt_addi", 32'h0, 4, 1, 32'd6);
    run_to_trap("misaligned_lw", 4);
    imem[0] = 32'hFC00_0000;
    do_reset();
    run_to_trap("bad_opcode", 3);
    imem[0] = enc_r(6'h21, 5'd1, 5'd2, 5'd3);
    do_reset();
    run_to_trap("bad_funct", 3);
    imem[0] = enc_i(OpAddi, 5'd0, 5'd1, 16'd1);
    do_reset();
    step_check("recover", 32'h0, 4, 1, 32'd1);

    // Reset while a store is stalled in MEM
    imem[0] = enc_i(OpAddi, 5'd0, 5'd1, 16'd9);
    imem[1] = enc_i(OpSw, 5'd0, 5'd1, 16'd0);
    do_reset();
    step_check("mid_addi", 32'h0, 4, 1, 32'd9);
    d_stall = 5;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #3;
      if (D_req === 1'b1) break;
    end
    check32("mid_dreq_seen", {31'd0, D_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #3;
    check32("mid_rst_dreq", {31'd0, D_req}, 32'd0);
    check32("mid_rst_ir_addr", IR_addr, 32'd0);
    rst = 1'b0;
    d_stall = 0;
    imem[0] = enc_r(FnAdd, 5'd1, 5'd1, 5'd3);
    step_check("mid_regs_cleared", 32'h0, 4, 1, 32'd0);
    check32("mid_store_dropped", dmem[0], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
